// File: rtl/univ_shift_counter_pkg.sv
// Shared mode encodings for the universal shift/count register.
package univ_reg_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_UP   = 3'b110;
  localparam logic [MODE_W-1:0] MODE_DOWN = 3'b111;

endpackage

// File: rtl/univ_shift_counter_mod_count_next.sv
// Combinational modulo up/down next-value generator with wrap strobe.
module mod_count_next #(
  parameter int WIDTH = 8,
  parameter int MOD   = 2**WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  output logic [WIDTH-1:0] nxt,
  output logic             wrp
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);

  // Out-of-range values (q > MAXV) wrap to zero when counting up.
  always_comb begin
    if (dir) begin
      wrp = (q == '0);
      nxt = wrp ? MAXV : q - 1'b1;
    end else begin
      wrp = (q >= MAXV);
      nxt = wrp ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/univ_shift_counter.sv
// Universal register: hold, load, shift, rotate and modulo up/down count with sticky wrap.
module univ_shift_counter
  import univ_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MOD   = 2**WIDTH
) (
  input  logic              clk,
  input  logic              r,
  input  logic              ce,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  D,
  input  logic              sil,
  input  logic              sir,
  output logic [WIDTH-1:0]  Q,
  output logic              tc,
  output logic              wrap
);

  logic [WIDTH-1:0] cnt_nxt;
  logic             cnt_wrp;
  logic             is_cnt;

  mod_count_next #(.WIDTH(WIDTH), .MOD(MOD)) u_cnt (
    .q   (Q),
    .dir (mode == MODE_DOWN),
    .nxt (cnt_nxt),
    .wrp (cnt_wrp)
  );

  assign is_cnt = (mode == MODE_UP) || (mode == MODE_DOWN);
  assign tc     = ce && is_cnt && cnt_wrp;

  // Register stage: Q/wrap update on the edge following the selected op.
  always_ff @(posedge clk) begin
    if (r) begin
      Q    <= '0;
      wrap <= 1'b0;
    end else if (ce) begin
      case (mode)
        MODE_LOAD: begin
          Q    <= D;
          wrap <= 1'b0;
        end
        MODE_SHL:  Q <= {Q[WIDTH-2:0], sil};
        MODE_SHR:  Q <= {sir, Q[WIDTH-1:1]};
        MODE_ROL:  Q <= {Q[WIDTH-2:0], Q[WIDTH-1]};
        MODE_ROR:  Q <= {Q[0], Q[WIDTH-1:1]};
        MODE_UP, MODE_DOWN: begin
          Q <= cnt_nxt;
          if (cnt_wrp) wrap <= 1'b1;
        end
        default: Q <= Q;
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_counter.sv
// Scoreboard bench for univ_shift_counter at WIDTH=8, MOD=10.
module tb_univ_shift_counter;
  import univ_reg_pkg::*;

  logic       clk = 1'b0;
  logic       r = 1'b0, ce = 1'b0, sil = 1'b0, sir = 1'b0;
  logic [2:0] mode = MODE_HOLD;
  logic [7:0] D = 8'h00;
  logic [7:0] Q;
  logic       tc, wrap;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       etc;
    logic [7:0] eq;
    logic       ew;
  } exp_t;

  exp_t sb[$];

  univ_shift_counter #(.WIDTH(8), .MOD(10)) dut (
    .clk(clk), .r(r), .ce(ce), .mode(mode), .D(D),
    .sil(sil), .sir(sir), .Q(Q), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // One cycle of stimulus; expected tc for this cycle, Q/wrap after the edge.
  task automatic op(input bit rr, input bit cc, input logic [2:0] m, input logic [7:0] d,
                    input bit sl, input bit sr, input bit etc, input logic [7:0] eq, input bit ew);
    exp_t e;
    @(posedge clk);
    #1;
    r = rr; ce = cc; mode = m; D = d; sil = sl; sir = sr;
    e.etc = etc; e.eq = eq; e.ew = ew;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("tc", {7'b0, tc}, {7'b0, e.etc});
        @(posedge clk);
        #1;
        chk("Q", Q, e.eq);
        chk("wrap", {7'b0, wrap}, {7'b0, e.ew});
      end
    end
  end

  initial begin : stimulus
    // reset has priority over a pending LOAD
    op(1, 1, MODE_LOAD, 8'hA5, 0, 0, 0, 8'h00, 0);
    op(0, 1, MODE_LOAD, 8'hA5, 0, 0, 0, 8'hA5, 0);
    // up count through the modulus
    op(0, 1, MODE_LOAD, 8'h07, 0, 0, 0, 8'h07, 0);
    op(0, 1, MODE_UP,   8'h00, 0, 0, 0, 8'h08, 0);
    op(0, 1, MODE_UP,   8'h00, 0, 0, 0, 8'h09, 0);
    op(0, 1, MODE_UP,   8'h00, 0, 0, 1, 8'h00, 1);
    op(0, 1, MODE_UP,   8'h00, 0, 0, 0, 8'h01, 1);
    op(0, 1, MODE_HOLD, 8'h00, 0, 0, 0, 8'h01, 1);
    op(0, 1, MODE_LOAD, 8'h22, 0, 0, 0, 8'h22, 0);
    // down count through zero
    op(0, 1, MODE_LOAD, 8'h01, 0, 0, 0, 8'h01, 0);
    op(0, 1, MODE_DOWN, 8'h00, 0, 0, 0, 8'h00, 0);
    op(0, 1, MODE_DOWN, 8'h00, 0, 0, 1, 8'h09, 1);
    op(0, 1, MODE_DOWN, 8'h00, 0, 0, 0, 8'h08, 1);
    // shifts and rotates
    op(0, 1, MODE_LOAD, 8'h81, 0, 0, 0, 8'h81, 0);
    op(0, 1, MODE_ROL,  8'h00, 0, 0, 0, 8'h03, 0);
    op(0, 1, MODE_ROR,  8'h00, 0, 0, 0, 8'h81, 0);
    op(0, 1, MODE_SHL,  8'h00, 1, 0, 0, 8'h03, 0);
    op(0, 1, MODE_SHR,  8'h00, 0, 0, 0, 8'h01, 0);
    op(0, 1, MODE_SHL,  8'h00, 0, 1, 0, 8'h02, 0);
    op(0, 1, MODE_SHR,  8'h00, 0, 1, 0, 8'h81, 0);
    // out-of-range value
    op(0, 1, MODE_LOAD, 8'hF0, 0, 0, 0, 8'hF0, 0);
    op(0, 1, MODE_UP,   8'h00, 0, 0, 1, 8'h00, 1);
    op(0, 1, MODE_LOAD, 8'hF0, 0, 0, 0, 8'hF0, 0);
    op(0, 1, MODE_DOWN, 8'h00, 0, 0, 0, 8'hEF, 0);
    // clock enable low holds everything and masks tc
    op(0, 1, MODE_LOAD, 8'h09, 0, 0, 0, 8'h09, 0);
    for (int i = 0; i < 5; i++) op(0, 0, MODE_UP, 8'h00, 0, 0, 0, 8'h09, 0);
    op(0, 1, MODE_UP,   8'h00, 0, 0, 1, 8'h00, 1);
    op(0, 0, MODE_LOAD, 8'h03, 0, 0, 0, 8'h00, 1);
    // reset mid-count
    op(0, 1, MODE_LOAD, 8'h02, 0, 0, 0, 8'h02, 0);
    op(0, 1, MODE_UP,   8'h00, 0, 0, 0, 8'h03, 0);
    op(0, 1, MODE_UP,   8'h00, 0, 0, 0, 8'h04, 0);
    op(0, 1, MODE_UP,   8'h00, 0, 0, 0, 8'h05, 0);
    op(1, 1, MODE_UP,   8'h00, 0, 0, 0, 8'h00, 0);
    op(0, 1, MODE_UP,   8'h00, 0, 0, 0, 8'h01, 0);
    // reset clears a set wrap flag
    op(0, 1, MODE_DOWN, 8'h00, 0, 0, 0, 8'h00, 0);
    op(0, 1, MODE_DOWN, 8'h00, 0, 0, 1, 8'h09, 1);
    op(1, 1, MODE_DOWN, 8'h00, 0, 0, 0, 8'h00, 0);
    op(0, 1, MODE_HOLD, 8'h00, 0, 0, 0, 8'h00, 0);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
